// File: rtl/scmi_doorbell_dispatcher_pkg.sv
// Shared types and defaults for the SCMI doorbell dispatcher and its ID queue.
package scmi_dispatch_pkg;

    localparam int unsigned DefNumChannels = 64;
    localparam int unsigned DefFifoDepth   = 8;
    localparam int unsigned DefChanIdWidth = $clog2(DefNumChannels);

    typedef logic [DefChanIdWidth-1:0] chan_id_t;

    // Channel index reached by stepping 'offset' positions past 'base', wrapping at n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/scmi_doorbell_dispatcher_fifo.sv
// Channel-ID queue: synchronous active-high reset on control state only, storage is not reset.
module scmi_db_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok;
    logic             pop_ok;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & valid_o;

    // Head is gated by valid so the output reads zero whenever the queue is empty.
    assign data_o = valid_o ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/scmi_doorbell_dispatcher.sv
// Collects doorbell edges into pending bits, grants them round-robin into an ID queue
// and raises one interrupt to the PMU core while the queue holds anything.
module scmi_doorbell_dispatcher
    import scmi_dispatch_pkg::*;
#(
    parameter  int unsigned NumChannels = DefNumChannels,
    parameter  int unsigned FifoDepth   = DefFifoDepth,
    localparam int unsigned ChanIdWidth = $clog2(NumChannels)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumChannels-1:0] doorbell_i,
    input  logic [NumChannels-1:0] mask_i,
    output logic [ChanIdWidth-1:0] id_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   irq_o,
    output logic [NumChannels-1:0] pending_o
);

    logic [NumChannels-1:0] db_q;
    logic [NumChannels-1:0] pending_q;
    logic [NumChannels-1:0] edge_d;
    logic [NumChannels-1:0] grant_mask;
    logic [ChanIdWidth-1:0] last_grant_q;
    logic [ChanIdWidth-1:0] grant_id;
    logic                   grant_found;
    logic                   grant_en;
    logic                   fifo_full;
    logic                   fifo_valid;
    logic                   fifo_pop;

    assign edge_d = doorbell_i & ~db_q & ~mask_i;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 1; i <= NumChannels; i++) begin
            idx = rr_index(32'(last_grant_q), i, NumChannels);
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_id    = ChanIdWidth'(idx);
            end
        end
    end

    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign grant_en   = grant_found & ~fifo_full;
    assign grant_mask = grant_en ? ({{(NumChannels-1){1'b0}}, 1'b1} << grant_id) : '0;

    // A fresh edge on the granted channel re-sets its pending bit in the same clock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_q         <= '0;
            pending_q    <= '0;
            last_grant_q <= ChanIdWidth'(NumChannels - 1);
        end else begin
            db_q      <= doorbell_i;
            pending_q <= (pending_q & ~grant_mask) | edge_d;
            if (grant_en) begin
                last_grant_q <= grant_id;
            end
        end
    end

    assign fifo_pop = fifo_valid & ready_i;

    scmi_db_fifo #(
        .Depth (FifoDepth),
        .Width (ChanIdWidth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant_en),
        .data_i  (grant_id),
        .pop_i   (fifo_pop),
        .data_o  (id_o),
        .valid_o (fifo_valid),
        .full_o  (fifo_full)
    );

    assign valid_o   = fifo_valid;
    assign irq_o     = fifo_valid;
    assign pending_o = pending_q;

endmodule

// File: doc/scmi_doorbell_dispatcher.md
SCMI_DOORBELL_DISPATCHER -- requirements
Module: scmi_doorbell_dispatcher

Interface
REQ-001 SHALL have parameter NumChannels, default 64: number of doorbell lines (2..64).
REQ-002 SHALL have parameter FifoDepth, default 8: channel-ID queue depth (power of two, >=2).
REQ-003 SHALL have localparam ChanIdWidth = $clog2(NumChannels).
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 doorbell_i  input  NumChannels  level doorbell IRQs from the SCMI mailbox (irq_doorbell_o), bit n = channel n.
REQ-007 mask_i  input  NumChannels  1 = channel n ignored.
REQ-008 id_o  output  ChanIdWidth  channel ID at FIFO head.
REQ-009 valid_o  output  1  id_o valid.
REQ-010 ready_i  input  1  consumer accepts id_o.
REQ-011 irq_o  output  1  single interrupt to the PMU core, high while queue non-empty.
REQ-012 pending_o  output  NumChannels  per-channel pending (latched, not yet queued) bits.

Function
REQ-013 SHALL register doorbell_i into db_q each cycle; edge[n] = doorbell_i[n] & ~db_q[n] & ~mask_i[n].
REQ-014 SHALL set pending[n] on the clock after edge[n]; masked edges are dropped, not deferred.
REQ-015 SHALL coalesce: an edge on an already-pending channel leaves one pending entry.
REQ-016 SHALL grant at most one pending channel per cycle, round-robin, starting search at (last_grant+1) mod NumChannels, wrapping.
REQ-017 SHALL grant only when FIFO count < FifoDepth at cycle start; a simultaneous pop does not enable a grant in a full cycle.
REQ-018 On grant SHALL clear pending[g], push g into FIFO, update last_grant to g, all on the same clock.
REQ-019 If edge[g] coincides with clearing pending[g], set SHALL win: pending[g] stays 1.
REQ-020 Latency: doorbell rising in cycle n, empty FIFO, no competition -> pending_o high cycle n+1 -> valid_o high cycle n+2.
REQ-021 valid_o = (count != 0); id_o = head entry; both purely from registers.
REQ-022 Pop occurs when valid_o & ready_i; id_o SHALL hold stable while valid_o & ~ready_i.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; read/write pointers wrap modulo FifoDepth.
REQ-024 irq_o SHALL equal valid_o.
REQ-025 Full FIFO: pending bits retained, no loss, arbitration resumes the cycle after count drops below FifoDepth.
REQ-026 Changing mask_i SHALL NOT clear already-pending or queued entries.

Reset
REQ-027 rst_i high SHALL clear db_q, pending, FIFO pointers/count, last_grant (to NumChannels-1, so channel 0 searched first).
REQ-028 Reset outputs: valid_o=0, irq_o=0, id_o=0, pending_o=0.
REQ-029 Reset mid-operation SHALL discard all pending and queued IDs; a doorbell held high across reset release SHALL be seen as a new edge (db_q=0).

Structure
REQ-030 Package scmi_dispatch_pkg SHALL hold chan_id_t and the default NumChannels/FifoDepth constants.
REQ-031 Sub-module scmi_db_fifo SHALL implement the synchronous-reset, active-high FIFO; round-robin logic stays in the top.
REQ-032 Implementation SHALL be 120-400 lines RTL, no latches, no combinational path from ready_i to id_o.

Verification (NumChannels=64, FifoDepth=8)
REQ-033 Raise doorbell_i[5] at cycle 10, ready_i=1 -> pending_o[5] cycle 11, valid_o=1 id_o=5 cycle 12, irq_o falls cycle 13.
REQ-034 Raise bits 3,7,60 same cycle, ready_i=1 -> ids popped in order 3,7,60; then raise 1,7 with last_grant=60 -> order 1,7.
REQ-035 ready_i=0, pulse 10 distinct channels 0..9 -> FIFO holds 0..7, pending_o bits 8,9 stay 1; release ready_i -> all 10 IDs delivered, none lost.
REQ-036 mask_i[4]=1, pulse doorbell_i[4] -> no pending, no valid_o; pulse channel 4 twice while pending -> one ID 4 delivered.
REQ-037 Queue 3 IDs, assert rst_i one cycle with doorbell_i[2] held high -> valid_o=0 after reset, then ID 2 queued (edge re-seen).
